// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Execute raises start_i with the operands and stalls until ready_o; result_o then
// carries {remainder, quotient} for the HI/LO write path.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   signed_div_i    1 = two's-complement divide, 0 = unsigned
//   opdata1_i       dividend
//   opdata2_i       divisor
//   start_i         request, held high until the result has been consumed
//   annul_i         abort an in-flight divide
//   result_o        {remainder, quotient}, valid while ready_o = 1
//   ready_o         result valid
//
// state  | meaning
// IDLE   | waiting for start_i; outputs cleared
// BYZERO | divisor was zero; report a zero result next cycle
// ON     | running the restoring iterations (cnt = steps done)
// END    | result presented until start_i drops
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     partial, diff;
  logic               accept;

  assign accept  = start_i && !annul_i;
  assign mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign partial = {rem_q, dvd_q[WIDTH-1]};
  // remainder < divisor keeps the true difference within WIDTH bits, so the
  // top bit of the WIDTH+1 wide subtraction is a reliable borrow flag
  assign diff    = partial - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)                   state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH))  state_d = S_END;
      end
      S_END:    if (!start_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (accept && opdata2_i != '0) begin
          dvd_d  = mag1;
          dsr_d  = mag2;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          rneg_d = signed_div_i && opdata1_i[WIDTH-1];
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = !annul_i;
        cnt_d    = '0;
      end
      S_ON: begin
        if (annul_i) begin
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q < CW'(WIDTH)) begin
          if (!diff[WIDTH]) rem_d = diff[WIDTH-1:0];
          else              rem_d = partial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q + CW'(1);
        end else begin
          result_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -dvd_q : dvd_q)};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a divide, optionally scrambles inputs after the start edge, and checks
  // latency (edges after the start edge), result, hold in END and release to IDLE.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat, input bit scramble);
    int n;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    tick();
    if (scramble) begin
      op1        = ~a;
      op2        = $urandom | 32'h1;
      signed_div = ~sgn;
    end
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " result"}, result, exp);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    chk({tag, " hold ready"}, 64'(ready), 64'd1);
    chk({tag, " hold result"}, result, exp);
    start = 1'b0;
    tick();
    chk({tag, " release ready"}, 64'(ready), 64'd0);
    chk({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] exp;
    longint      la, lb, lq, lr;
    bit          seen;

    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
    run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b1);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33, 1'b1);
    run_div("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 1'b0);
    run_div("div -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33, 1'b1);
    run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 1'b0);
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 1, 1'b0);

    // start with annul in IDLE must not launch a divide
    start = 1'b1;
    annul = 1'b1;
    op1   = 32'd9;
    op2   = 32'd3;
    tick();
    tick();
    start = 1'b0;
    annul = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("idle annul no ready", 64'(seen), 64'd0);

    // annul ten cycles into ON
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    start      = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    chk("annul ready", 64'(ready), 64'd0);
    chk("annul result", result, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("annul no ready", 64'(seen), 64'd0);
    run_div("divu max/16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, 1'b0);

    // annul in BYZERO
    op1   = 32'd5;
    op2   = 32'd0;
    start = 1'b1;
    tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    seen  = ready;
    repeat (3) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("byzero annul no ready", 64'(seen), 64'd0);

    // synchronous reset at cnt = 20
    op1   = 32'd1000;
    op2   = 32'd3;
    start = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("midrst ready", 64'(ready), 64'd0);
    chk("midrst result", result, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("midrst no ready", 64'(seen), 64'd0);
    run_div("divu 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 1'b1);

    // random operands against a 64-bit behavioural model
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = b >> 27;
      if (b == 32'd0) b = 32'd3;
      if (i % 2 == 1) begin
        la  = longint'($signed(a));
        lb  = longint'($signed(b));
        lq  = la / lb;
        lr  = la % lb;
        exp = {lr[31:0], lq[31:0]};
      end else begin
        exp = {a % b, a / b};
      end
      run_div($sformatf("rand %0d", i), 1'(i % 2), a, b, exp, 33, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
